// File: rtl/simd_alu_arbiter_if.sv
// Bundle between the requesters, the SIMD ALU and the response consumer.
// The arbiter takes the slave side; the environment takes the master side.
interface simd_alu_arbiter_if #(
    parameter int LANES = 4,
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int W    = 32 * LANES;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [2*N_REQ-1:0] req_op;
    logic [W*N_REQ-1:0] req_a;
    logic [W*N_REQ-1:0] req_b;

    logic [1:0]         alu_op;
    logic [W-1:0]       alu_a;
    logic [W-1:0]       alu_b;
    logic [W-1:0]       alu_result;

    logic               resp_valid;
    logic               resp_ready;
    logic [ID_W-1:0]    resp_id;
    logic [W-1:0]       resp_data;
    logic               resp_err;

    logic               busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output resp_valid, resp_id, resp_data, resp_err,
        input  resp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  resp_valid, resp_id, resp_data, resp_err,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/simd_alu_arbiter.sv
// Round-robin front end that serialises SIMD ADD/MUL requests onto one
// registered ALU and returns each result through a valid/ready response.
module simd_alu_arbiter #(
    parameter int LANES = 4,
    parameter int N_REQ = 4
) (
    input  logic clk,
    input  logic reset,
    simd_alu_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int W    = 32 * LANES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            accept;
    logic [N_REQ-1:0] req_ready_c;

    // Search starts at rr_ptr and wraps, so the first hit is the winner.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_found && !reset;

    always_comb begin
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d = grant_id;
                    op_d = bus.req_op[2*grant_id +: 2];
                    a_d  = bus.req_a[grant_id*W +: W];
                    b_d  = bus.req_b[grant_id*W +: W];
                    if (int'(grant_id) == N_REQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_id + 1'b1;
                    end
                    // Illegal ops skip the ALU and answer with an error.
                    if (op_d[1]) begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                resp_data_d = bus.alu_result;
                resp_err_d  = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= 2'b11;
            a_q         <= '0;
            b_q         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.alu_op     = (state_q == ISSUE) ? op_q : 2'b11;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
